// File: rtl/collective_pkg.sv
// Shared definitions for the collective-router flit injector: opcodes, FSM
// states, fixed flit field widths and the broadcast classifier.
package collective_pkg;

    localparam int OPC_W  = 4;
    localparam int PIDX_W = 3;
    localparam int SEED_W = 32;

    localparam logic [OPC_W-1:0] OPC_SCAN             = 4'd3;
    localparam logic [OPC_W-1:0] OPC_ALLTOALL         = 4'd4;
    localparam logic [OPC_W-1:0] OPC_LARGE_BCAST      = 4'd5;
    localparam logic [OPC_W-1:0] OPC_MEDIUM_BCAST     = 4'd6;
    localparam logic [OPC_W-1:0] OPC_SHORT_BCAST      = 4'd7;
    localparam logic [OPC_W-1:0] OPC_SCATTER          = 4'd8;
    localparam logic [OPC_W-1:0] OPC_LARGE_ALLGATHER  = 4'd9;
    localparam logic [OPC_W-1:0] OPC_SHORT_ALLGATHER  = 4'd10;
    localparam logic [OPC_W-1:0] OPC_GATHER           = 4'd11;
    localparam logic [OPC_W-1:0] OPC_SHORT_REDUCE     = 4'd12;
    localparam logic [OPC_W-1:0] OPC_LARGE_REDUCE     = 4'd13;
    localparam logic [OPC_W-1:0] OPC_SHORT_ALLREDUCE  = 4'd14;
    localparam logic [OPC_W-1:0] OPC_LARGE_ALLREDUCE  = 4'd15;

    // Header bits that do not depend on configuration: valid + opcode + port index.
    localparam int FLIT_FIXED_W = 1 + OPC_W + PIDX_W;

    // Field offsets at the default configuration (FLIT_W 85, NODE_ID_W 4, SEQ_W 8).
    localparam int FLIT_PAY_LSB_DEF   = 0;
    localparam int FLIT_SEQ_LSB_DEF   = 65;
    localparam int FLIT_PIDX_LSB_DEF  = 73;
    localparam int FLIT_NODE_LSB_DEF  = 76;
    localparam int FLIT_OPC_LSB_DEF   = 80;
    localparam int FLIT_VALID_BIT_DEF = 84;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int flit_pay_w(input int flit_w, input int node_w, input int seq_w);
        return flit_w - FLIT_FIXED_W - node_w - seq_w;
    endfunction

    function automatic logic is_bcast(input logic [OPC_W-1:0] opc);
        return (opc == OPC_LARGE_BCAST) || (opc == OPC_MEDIUM_BCAST) ||
               (opc == OPC_SHORT_BCAST);
    endfunction

endpackage

// File: rtl/collective_inject_port.sv
// One inject port: remaining-flit down-counter, sequence index, valid/ready
// handshake register and combinational flit builder.
module collective_inject_port
    import collective_pkg::*;
#(
    parameter int FLIT_W    = 85,
    parameter int NODE_ID_W = 4,
    parameter int SEQ_W     = 8,
    parameter int LEN_W     = 10,
    parameter int PORT_IDX  = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 launch,
    input  logic                 en,
    input  logic [LEN_W-1:0]     len,
    input  logic [OPC_W-1:0]     opcode,
    input  logic [NODE_ID_W-1:0] node_id,
    input  logic [SEED_W-1:0]    seed,
    input  logic                 ready,
    output logic [FLIT_W-1:0]    flit,
    output logic                 valid,
    output logic                 valid_next
);

    localparam int PAY_W = flit_pay_w(FLIT_W, NODE_ID_W, SEQ_W);

    logic             valid_q, valid_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [LEN_W-1:0] idx_q, idx_d;

    logic [SEED_W-1:0] pay_sum;
    logic [PIDX_W-1:0] pidx;

    always_comb begin
        valid_d = valid_q;
        rem_d   = rem_q;
        idx_d   = idx_q;
        if (launch) begin
            valid_d = en;
            rem_d   = len;
            idx_d   = '0;
        end else if (valid_q && ready) begin
            idx_d = idx_q + LEN_W'(1);
            rem_d = rem_q - LEN_W'(1);
            if (rem_q == LEN_W'(1)) begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            rem_q   <= '0;
            idx_q   <= '0;
        end else begin
            valid_q <= valid_d;
            rem_q   <= rem_d;
            idx_q   <= idx_d;
        end
    end

    // Payload follows the full index, so it keeps counting after seq wraps.
    assign pay_sum = seed + SEED_W'(idx_q);
    assign pidx    = is_bcast(opcode) ? '0 : PIDX_W'(PORT_IDX);

    // Flit is forced to zero whenever the port is not presenting data.
    assign flit = valid_q ? {1'b1, opcode, node_id, pidx, SEQ_W'(idx_q), PAY_W'(pay_sum)}
                          : '0;

    assign valid      = valid_q;
    assign valid_next = valid_d;

endmodule

// File: rtl/collective_injector.sv
// Per-node collective traffic source: accepts a command, then streams msg_len
// flits on every selected port, each with its own valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for start; bad opcode pulses err, empty command goes to DONE
// SEND  | ports streaming; leaves once every enabled port has drained
// DONE  | done pulse for one cycle, then back to IDLE
module collective_injector
    import collective_pkg::*;
#(
    parameter int NUM_PORTS = 6,
    parameter int FLIT_W    = 85,
    parameter int NODE_ID_W = 4,
    parameter int SEQ_W     = 8,
    parameter int LEN_W     = 10
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [OPC_W-1:0]            opcode,
    input  logic [LEN_W-1:0]            msg_len,
    input  logic [NUM_PORTS-1:0]        port_mask,
    input  logic [NODE_ID_W-1:0]        node_id,
    input  logic [SEED_W-1:0]           payload_seed,
    output logic [NUM_PORTS*FLIT_W-1:0] inject_flit,
    output logic [NUM_PORTS-1:0]        inject_valid,
    input  logic [NUM_PORTS-1:0]        inject_ready,
    output logic                        busy,
    output logic                        done,
    output logic                        err
);

    state_e                 state_q, state_d;
    logic [OPC_W-1:0]       opcode_q, opcode_d;
    logic [LEN_W-1:0]       msg_len_q, msg_len_d;
    logic [NUM_PORTS-1:0]   port_mask_q, port_mask_d;
    logic [NODE_ID_W-1:0]   node_id_q, node_id_d;
    logic [SEED_W-1:0]      seed_q, seed_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic                   launch;
    logic [NUM_PORTS-1:0]   valid_next;

    always_comb begin
        state_d     = state_q;
        opcode_d    = opcode_q;
        msg_len_d   = msg_len_q;
        port_mask_d = port_mask_q;
        node_id_d   = node_id_q;
        seed_d      = seed_q;
        err_d       = 1'b0;
        launch      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (opcode < OPC_SCAN) begin
                        err_d = 1'b1;
                    end else if ((msg_len == '0) || (port_mask == '0)) begin
                        state_d = ST_DONE;
                    end else begin
                        opcode_d    = opcode;
                        msg_len_d   = msg_len;
                        port_mask_d = port_mask;
                        node_id_d   = node_id;
                        seed_d      = payload_seed;
                        launch      = 1'b1;
                        state_d     = ST_SEND;
                    end
                end
            end
            // Look at next-cycle valids so DONE is entered on the final handshake edge.
            ST_SEND: begin
                if (!(|valid_next)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        done_d = (state_d == ST_DONE);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            opcode_q    <= '0;
            msg_len_q   <= '0;
            port_mask_q <= '0;
            node_id_q   <= '0;
            seed_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            opcode_q    <= opcode_d;
            msg_len_q   <= msg_len_d;
            port_mask_q <= port_mask_d;
            node_id_q   <= node_id_d;
            seed_q      <= seed_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        collective_inject_port #(
            .FLIT_W    (FLIT_W),
            .NODE_ID_W (NODE_ID_W),
            .SEQ_W     (SEQ_W),
            .LEN_W     (LEN_W),
            .PORT_IDX  (p)
        ) u_port (
            .clk        (clk),
            .rst        (rst),
            .launch     (launch),
            .en         (port_mask_d[p]),
            .len        (msg_len_d),
            .opcode     (opcode_q),
            .node_id    (node_id_q),
            .seed       (seed_q),
            .ready      (inject_ready[p]),
            .flit       (inject_flit[p*FLIT_W +: FLIT_W]),
            .valid      (inject_valid[p]),
            .valid_next (valid_next[p])
        );
    end

    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_collective_injector.sv
// Scoreboard bench for collective_injector: directed commands push expected
// flits/pulses with their cycle numbers; a monitor pops and compares.
module tb_collective_injector;

    localparam int NP = 6;
    localparam int FW = 85;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [3:0]        opcode;
    logic [9:0]        msg_len;
    logic [NP-1:0]     port_mask;
    logic [3:0]        node_id;
    logic [31:0]       payload_seed;
    logic [NP*FW-1:0]  inject_flit;
    logic [NP-1:0]     inject_valid;
    logic [NP-1:0]     inject_ready;
    logic              busy;
    logic              done;
    logic              err;

    collective_injector dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .opcode       (opcode),
        .msg_len      (msg_len),
        .port_mask    (port_mask),
        .node_id      (node_id),
        .payload_seed (payload_seed),
        .inject_flit  (inject_flit),
        .inject_valid (inject_valid),
        .inject_ready (inject_ready),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [FW-1:0] flit;
        int            at_cyc;
    } exp_t;

    exp_t exp_q [NP][$];
    int   done_q [$];
    int   err_q [$];

    int vectors     = 0;
    int miscompares = 0;

    logic [NP-1:0] hold_v = '0;
    logic [FW-1:0] hold_f [NP];
    exp_t          mon_e;
    logic [FW-1:0] mon_f;
    int            mon_c;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic flag(input string name, input string got, input string want);
        vectors++;
        miscompares++;
        $display("FAIL %s @cyc %0d: got %s, expected %s", name, cyc, got, want);
    endtask

    function automatic logic [FW-1:0] mk_flit(input logic [3:0] opc, input logic [3:0] node,
                                               input int p, input int i, input logic [31:0] seed);
        logic [2:0]  pf;
        logic [7:0]  sq;
        logic [31:0] pay;
        pf  = (opc >= 4'd5 && opc <= 4'd7) ? 3'd0 : 3'(p);
        sq  = 8'(i);
        pay = seed + 32'(i);
        return {1'b1, opc, node, pf, sq, 33'd0, pay};
    endfunction

    task automatic push_flit(input int p, input logic [3:0] opc, input logic [3:0] node,
                             input logic [31:0] seed, input int i, input int at);
        exp_t e;
        e.flit   = mk_flit(opc, node, p, i, seed);
        e.at_cyc = at;
        exp_q[p].push_back(e);
    endtask

    // Called at a negedge; start is sampled at the next posedge, cycle t.
    task automatic issue(input logic [3:0] opc, input int len, input logic [NP-1:0] mask,
                         input logic [3:0] node, input logic [31:0] seed,
                         input bit auto_push, output int t);
        opcode       = opc;
        msg_len      = 10'(len);
        port_mask    = mask;
        node_id      = node;
        payload_seed = seed;
        start        = 1'b1;
        t = cyc + 1;
        if (opc < 4'd3) begin
            err_q.push_back(t);
        end else if (len == 0 || mask == '0) begin
            done_q.push_back(t);
        end else if (auto_push) begin
            for (int p = 0; p < NP; p++)
                if (mask[p])
                    for (int i = 0; i < len; i++)
                        push_flit(p, opc, node, seed, i, t + 1 + i);
            done_q.push_back(t + len);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int limit);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) flag(name, "no done", "done pulse");
    endtask

    task automatic check_drained(input string name);
        for (int p = 0; p < NP; p++) chk({name, "_flits_left"}, exp_q[p].size(), 0);
        chk({name, "_done_left"}, done_q.size(), 0);
        chk({name, "_err_left"}, err_q.size(), 0);
    endtask

    task automatic check_quiet(input string name);
        chk({name, "_valid"}, inject_valid, '0);
        chk({name, "_flit"}, inject_flit, '0);
        chk({name, "_busy"}, busy, 1'b0);
        chk({name, "_done"}, done, 1'b0);
        chk({name, "_err"}, err, 1'b0);
    endtask

    // Monitor: samples 2 time units after the negedge, after stimulus updates.
    always begin
        @(negedge clk);
        #2;
        if (!rst) begin
            hold_v = '0;
        end else begin
            mon_c = cyc;
            for (int p = 0; p < NP; p++) begin
                mon_f = inject_flit[p*FW +: FW];
                if (inject_valid[p]) begin
                    if (exp_q[p].size() == 0) begin
                        flag($sformatf("unexpected_valid_p%0d", p), "valid=1", "valid=0");
                    end else begin
                        if (hold_v[p]) chk($sformatf("stall_hold_p%0d", p), mon_f, hold_f[p]);
                        if (inject_ready[p]) begin
                            hold_v[p] = 1'b0;
                            mon_e = exp_q[p].pop_front();
                            chk($sformatf("flit_p%0d", p), mon_f, mon_e.flit);
                            chk($sformatf("xfer_cyc_p%0d", p), mon_c + 1, mon_e.at_cyc);
                        end else begin
                            hold_v[p] = 1'b1;
                            hold_f[p] = mon_f;
                        end
                    end
                end else begin
                    if (hold_v[p]) flag($sformatf("valid_dropped_p%0d", p), "valid=0", "valid held");
                    hold_v[p] = 1'b0;
                end
            end
            if (done) begin
                if (done_q.size() == 0) flag("unexpected_done", "done=1", "done=0");
                else chk("done_cyc", mon_c, done_q.pop_front());
                chk("busy_in_done", busy, 1'b1);
            end
            if (err) begin
                if (err_q.size() == 0) flag("unexpected_err", "err=1", "err=0");
                else chk("err_cyc", mon_c, err_q.pop_front());
                chk("busy_on_err", busy, 1'b0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        bit pat [5];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        rst = 1'b1; start = 1'b0; opcode = '0; msg_len = '0; port_mask = '0;
        node_id = '0; payload_seed = '0; inject_ready = '0;
        #3 rst = 1'b0;
        #1 check_quiet("reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        inject_ready = '1;
        @(negedge clk);

        // Broadcast, all ports, ready high; inputs scrambled mid-command.
        issue(4'd7, 4, 6'h3F, 4'd5, 32'h100, 1'b1, t);
        chk("busy_after_start", busy, 1'b1);
        chk("valid_after_start", inject_valid, 6'h3F);
        opcode = 4'h9; msg_len = 10'd1; port_mask = '0; node_id = 4'hA; payload_seed = '0;
        wait_done("bcast_done", 40);
        @(negedge clk);
        chk("busy_cleared", busy, 1'b0);
        check_drained("bcast");

        // Back-to-back: issued in the first IDLE cycle; port 2 backpressured.
        t = cyc + 1;
        for (int i = 0; i < 3; i++) push_flit(0, 4'd8, 4'd3, 32'h2000, i, t + 1 + i);
        push_flit(2, 4'd8, 4'd3, 32'h2000, 0, t + 1);
        push_flit(2, 4'd8, 4'd3, 32'h2000, 1, t + 4);
        push_flit(2, 4'd8, 4'd3, 32'h2000, 2, t + 5);
        done_q.push_back(t + 5);
        issue(4'd8, 3, 6'b000101, 4'd3, 32'h2000, 1'b0, t);
        for (int k = 0; k < 5; k++) begin
            inject_ready[2] = pat[k];
            @(negedge clk);
        end
        inject_ready = '1;
        wait_done("bp_done", 40);
        @(negedge clk);
        check_drained("bp");

        // Rejected / empty commands.
        issue(4'd2, 4, 6'h3F, 4'd1, 32'h0, 1'b1, t);
        chk("err_busy_low", busy, 1'b0);
        repeat (4) @(negedge clk);
        issue(4'd4, 0, 6'h3F, 4'd1, 32'h0, 1'b1, t);
        chk("zero_len_done", done, 1'b1);
        chk("zero_len_valid", inject_valid, '0);
        repeat (4) @(negedge clk);
        issue(4'd10, 5, 6'h00, 4'd1, 32'h0, 1'b1, t);
        chk("zero_mask_done", done, 1'b1);
        repeat (4) @(negedge clk);
        check_drained("reject");

        // Start while busy must be ignored.
        issue(4'd13, 6, 6'b000001, 4'd1, 32'h7, 1'b1, t);
        start = 1'b1; opcode = 4'd15; msg_len = 10'd2; port_mask = 6'b100000;
        @(negedge clk);
        start = 1'b0;
        wait_done("busy_start_done", 40);
        repeat (6) @(negedge clk);
        check_drained("busy_start");

        // Sequence wrap past 255 and payload wrap past 2^32.
        issue(4'd9, 300, 6'b001000, 4'hC, 32'hFFFF_FF00, 1'b1, t);
        wait_done("wrap_done", 400);
        @(negedge clk);
        check_drained("wrap");

        // Asynchronous reset mid-SEND, then a fresh command.
        issue(4'd11, 20, 6'b110000, 4'd6, 32'h55, 1'b1, t);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1 check_quiet("mid_reset");
        for (int p = 0; p < NP; p++) exp_q[p].delete();
        done_q.delete();
        err_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        issue(4'd12, 5, 6'b000011, 4'd2, 32'h1000, 1'b1, t);
        wait_done("post_reset_done", 40);
        @(negedge clk);
        check_drained("post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
